dsp_dot_seq: RTL and testbench

Dot-product sequencer that sits directly upstream of an accumulating DSP block configured for multiply-accumulate with feedback. It accepts a valid/ready stream of signed operand pairs terminated by a last flag, drives the DSP A/B operands and accumulator-clear select, waits out the DSP pipeline latency, then captures the DSP P output and presents the final sum on a valid/ready result port. One vector is in flight at a time.

---
 rtl/dsp_dot_seq.sv | 174 +++++++++++++++++
 tb/tb_dsp_dot_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_dot_seq.sv
// dsp_dot_seq
// Streams signed operand pairs into an accumulating multiply-add DSP block,
// one vector at a time, and returns the dot product once the DSP pipeline
// has delivered the final sum.
//
// Ports
//   CLK, ARST              clock (rising edge), async active-high reset
//   in_valid/in_ready      operand-pair handshake; in_last marks the final pair
//   in_a, in_b             signed operands
//   dsp_a, dsp_b, dsp_clr  registered drive to the DSP; dsp_clr=1 restarts
//                          the accumulator from this product
//   dsp_p                  DSP accumulator output
//   out_valid/out_ready    result handshake
//   out_data               final dot product (wraps modulo 2^P_W)
//   out_count              number of elements in the vector
//   out_err                vector was cut at MAX_LEN without in_last
//
// State | Meaning
// ------+------------------------------------------------------------
// ACCUM | accepting pairs, feeding the DSP
// DRAIN | waiting out DSP latency before sampling dsp_p
// HOLD  | result presented, waiting for out_ready
module dsp_dot_seq #(
    parameter int  A_W     = 18,
    parameter int  B_W     = 18,
    parameter int  P_W     = 40,
    parameter int  LAT     = 2,
    parameter int  MAX_LEN = 256,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic                  CLK,
    input  logic                  ARST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [A_W-1:0] in_a,
    input  logic signed [B_W-1:0] in_b,
    input  logic                  in_last,
    output logic signed [A_W-1:0] dsp_a,
    output logic signed [B_W-1:0] dsp_b,
    output logic                  dsp_clr,
    input  logic signed [P_W-1:0] dsp_p,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [P_W-1:0] out_data,
    output logic [CW-1:0]         out_count,
    output logic                  out_err
);

    localparam int DW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic                  r_err;
    logic [DW-1:0]         r_drain;
    logic signed [A_W-1:0] r_dsp_a;
    logic signed [B_W-1:0] r_dsp_b;
    logic                  r_dsp_clr;
    logic signed [P_W-1:0] r_out_data;
    logic [CW-1:0]         r_out_count;
    logic                  r_out_err;

    logic w_accept;
    logic w_end;
    logic w_cnt_full;
    logic w_capture;
    logic w_release;

    // This element fills the vector to MAX_LEN.
    assign w_cnt_full = (r_cnt == CW'(MAX_LEN - 1));

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_end       = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ACCUM: begin
                w_accept = in_valid;
                w_end    = in_valid && (in_last || w_cnt_full);
                if (w_end) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = ACCUM;
                end
            end
            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_drain     <= '0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
            r_dsp_clr   <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_err   <= 1'b0;
        end else begin
            // Idle cycles feed zero operands so the DSP accumulator holds.
            r_dsp_a   <= w_accept ? in_a : '0;
            r_dsp_b   <= w_accept ? in_b : '0;
            r_dsp_clr <= w_accept && (r_cnt == '0);

            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                // A last flag on the MAX_LEN-th element is a normal end, not a cut.
                if (w_cnt_full && !in_last) begin
                    r_err <= 1'b1;
                end
            end

            // Loaded at the final accept; dsp_p is sampled once it runs down to zero,
            // one cycle after the product of that element reaches dsp_p.
            if (w_end) begin
                r_drain <= DW'(LAT);
            end else if (r_state == DRAIN && r_drain != '0) begin
                r_drain <= r_drain - 1'b1;
            end

            if (w_capture) begin
                r_out_data  <= dsp_p;
                r_out_count <= r_cnt;
                r_out_err   <= r_err;
            end

            if (w_release) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end
        end
    end

    // Depends only on state; ARST gating keeps it low while reset is held.
    assign in_ready  = (r_state == ACCUM) && !ARST;
    assign out_valid = (r_state == HOLD);
    assign dsp_a     = r_dsp_a;
    assign dsp_b     = r_dsp_b;
    assign dsp_clr   = r_dsp_clr;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_dsp_dot_seq.sv
// tb_dsp_dot_seq
// Drives directed and random operand streams into dsp_dot_seq, closes the loop
// through a behavioural accumulating DSP, and compares every cycle against a
// transaction-level model (list of vectors -> sums, counts, truncation flags,
// plus the expected handshake timing).
module tb_dsp_dot_seq;

    localparam int A_W     = 18;
    localparam int B_W     = 18;
    localparam int P_W     = 40;
    localparam int LAT     = 2;
    localparam int MAX_LEN = 4;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic                  CLK;
    logic                  ARST;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [A_W-1:0] in_a;
    logic signed [B_W-1:0] in_b;
    logic                  in_last;
    logic signed [A_W-1:0] dsp_a;
    logic signed [B_W-1:0] dsp_b;
    logic                  dsp_clr;
    logic signed [P_W-1:0] dsp_p;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [P_W-1:0] out_data;
    logic [CW-1:0]         out_count;
    logic                  out_err;

    dsp_dot_seq #(
        .A_W    (A_W),
        .B_W    (B_W),
        .P_W    (P_W),
        .LAT    (LAT),
        .MAX_LEN(MAX_LEN)
    ) u_dut (
        .CLK      (CLK),
        .ARST     (ARST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .dsp_a    (dsp_a),
        .dsp_b    (dsp_b),
        .dsp_clr  (dsp_clr),
        .dsp_p    (dsp_p),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_err  (out_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural DSP: accumulator register followed by LAT-1 output stages,
    // so a product presented after edge T is on dsp_p after edge T+LAT.
    logic signed [P_W-1:0] dsp_pipe [LAT] = '{default: '0};
    logic signed [P_W-1:0] w_pa;
    logic signed [P_W-1:0] w_pb;
    assign w_pa  = dsp_a;
    assign w_pb  = dsp_b;
    assign dsp_p = dsp_pipe[LAT-1];

    always @(posedge CLK) begin
        dsp_pipe[0] <= (dsp_clr ? '0 : dsp_pipe[0]) + w_pa * w_pb;
        for (int i = 1; i < LAT; i++) begin
            dsp_pipe[i] <= dsp_pipe[i-1];
        end
    end

    typedef struct {
        int a;
        int b;
        bit last;
        int gap;
    } elem_t;

    typedef struct {
        logic signed [P_W-1:0] data;
        int                    count;
        bit                    err;
    } res_t;

    elem_t stim_q[$];
    res_t  res_q[$];

    int     n_checks = 0;
    int     n_errors = 0;
    bit     m_ready;
    bit     exp_ov;
    int     cd;
    int     hold_left;
    int     cur_hold;
    int     m_n;
    longint m_sum;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int a, input int b, input bit last, input int gap);
        elem_t e;
        e.a = a; e.b = b; e.last = last; e.gap = gap;
        stim_q.push_back(e);
    endtask

    // One clock: drive, step to edge+1, advance model, compare.
    task automatic cycle();
        bit                    acc;
        bit                    ohs;
        elem_t                 e;
        res_t                  r;
        logic signed [A_W-1:0] ea;
        logic signed [B_W-1:0] eb;
        logic                  ec;

        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = A_W'($urandom);
        in_b     = B_W'($urandom);
        if (stim_q.size() > 0) begin
            if (stim_q[0].gap > 0) begin
                if (m_ready) stim_q[0].gap = stim_q[0].gap - 1;
            end else begin
                in_valid = 1'b1;
                in_a     = A_W'(stim_q[0].a);
                in_b     = B_W'(stim_q[0].b);
                in_last  = stim_q[0].last;
            end
        end
        if (exp_ov) begin
            out_ready = (hold_left == 0);
            if (hold_left > 0) hold_left--;
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
        acc = in_valid && m_ready;
        ohs = exp_ov && out_ready;

        @(posedge CLK);
        #1;

        ea = '0;
        eb = '0;
        ec = 1'b0;
        if (ohs) begin
            exp_ov  = 1'b0;
            m_ready = 1'b1;
            r = res_q.pop_front();
        end
        if (acc) begin
            e  = stim_q.pop_front();
            ea = A_W'(e.a);
            eb = B_W'(e.b);
            ec = (m_n == 0);
            m_sum += longint'(e.a) * longint'(e.b);
            m_n++;
            if (e.last || m_n == MAX_LEN) begin
                r.data  = m_sum[P_W-1:0];
                r.count = m_n;
                r.err   = !e.last;
                res_q.push_back(r);
                m_ready = 1'b0;
                cd      = LAT + 1;
                m_n     = 0;
                m_sum   = 0;
            end
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                exp_ov    = 1'b1;
                hold_left = cur_hold;
            end
        end

        chk("in_ready", 64'(in_ready), 64'(m_ready));
        chk("dsp_a", 64'(dsp_a), 64'(ea));
        chk("dsp_b", 64'(dsp_b), 64'(eb));
        chk("dsp_clr", 64'(dsp_clr), 64'(ec));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov && res_q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(res_q[0].data));
            chk("out_count", 64'(out_count), 64'(res_q[0].count));
            chk("out_err", 64'(out_err), 64'(res_q[0].err));
        end
    endtask

    task automatic run(input int hold_len);
        int budget;
        budget   = 2000;
        cur_hold = hold_len;
        while ((stim_q.size() > 0 || !m_ready || res_q.size() > 0) && budget > 0) begin
            cycle();
            budget--;
        end
        chk("run_done", 64'(stim_q.size() + res_q.size()), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_dsp_a"}, 64'(dsp_a), 64'(0));
        chk({tag, "_dsp_b"}, 64'(dsp_b), 64'(0));
        chk({tag, "_dsp_clr"}, 64'(dsp_clr), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_data"}, 64'(out_data), 64'(0));
        chk({tag, "_out_count"}, 64'(out_count), 64'(0));
        chk({tag, "_out_err"}, 64'(out_err), 64'(0));
    endtask

    // Reset asserted asynchronously between edges; outputs must clear at once.
    task automatic reset_pulse();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ARST      = 1'b1;
        #1;
        check_reset_outputs("arst");
        @(posedge CLK);
        #1;
        ARST = 1'b0;
        stim_q.delete();
        res_q.delete();
        exp_ov  = 1'b0;
        cd      = 0;
        m_n     = 0;
        m_sum   = 0;
        m_ready = 1'b1;
        #1;
        chk("arst_release_in_ready", 64'(in_ready), 64'(1));
    endtask

    function automatic int rnd_op();
        case ($urandom_range(0, 7))
            0:       return -131072;
            1:       return 131071;
            default: return int'($urandom_range(0, 262143)) - 131072;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int guard;
        ARST      = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_ready   = 1'b0;
        exp_ov    = 1'b0;
        cd        = 0;
        hold_left = 0;
        cur_hold  = 0;
        m_n       = 0;
        m_sum     = 0;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        ARST = 1'b0;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'(1));
        m_ready = 1'b1;

        // Basic vector: 1*2 + 3*4 + 5*6 = 44.
        push(1, 2, 1'b0, 0);
        push(3, 4, 1'b0, 0);
        push(5, 6, 1'b1, 0);
        run(0);

        // Single signed element, extreme operands.
        push(-131072, 131071, 1'b1, 0);
        run(0);

        // Gapped input: valid pattern 1,0,0,1,1 -> 49 + 6 - 5 = 50.
        push(7, 7, 1'b0, 0);
        push(2, 3, 1'b0, 2);
        push(-1, 5, 1'b1, 0);
        run(0);

        // Eight (1,1) with last only on the eighth: truncated 4, then clean 4.
        for (int i = 0; i < 8; i++) push(1, 1, (i == 7), 0);
        run(0);

        // Long hold with the next vector already waiting at the input.
        push(3, 3, 1'b1, 0);
        push(1, 1, 1'b1, 0);
        run(10);

        // Reset while draining: the result must never appear.
        push(9, 9, 1'b0, 0);
        push(1, 1, 1'b1, 0);
        cur_hold = 0;
        guard    = 0;
        while (cd == 0 && guard < 50) begin
            cycle();
            guard++;
        end
        chk("reached_drain", 64'(cd > 0), 64'(1));
        reset_pulse();
        repeat (6) cycle();
        push(2, 2, 1'b1, 0);
        run(0);

        // Random vectors, some without last (exercising truncation and carry-over).
        for (int v = 0; v < 40; v++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                push(rnd_op(), rnd_op(),
                     (i == len - 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
                     $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0);
            end
            run($urandom_range(0, 3));
        end
        push(rnd_op(), rnd_op(), 1'b1, 0);
        run(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
